mdl_spdet_nch: RTL and testbench

Parametrised multi-channel sync-pattern detector for the bubble cartridge boot path. It runs one zero-run counter per bubble data channel and accepts a sync tip on a channel after `ZERO_RUN` zeros followed by a "one" inside the slot window. A hunt/align/lock state machine declares sync only when every enabled channel has tipped within a bounded alignment window. It also adds a boot timeout and a fail flag, and sits between the bubble data deserialiser and the bootloader sequencer.

---
 rtl/mdl_spdet_nch.sv | 164 ++++++++++++++++
 tb/tb_mdl_spdet_nch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdl_spdet_nch.sv
// rtl/mdl_spdet_nch.sv - multi-channel bubble sync-pattern detector with hunt/align/lock FSM
module mdl_spdet_nch #(
    parameter int NCH       = 4,
    parameter int ZERO_RUN  = 128,
    parameter int ALIGN_WIN = 4,
    parameter int DLY_2B    = 8,
    parameter int TO_W      = 12
) (
    input  logic            i_MCLK,
    input  logic            i_SYS_RST_n,
    input  logic            i_CLK2M_PCEN_n,
    input  logic [NCH-1:0]  i_BDI,
    input  logic            i_GLCNT_RD,
    input  logic            i_SLOT_n,
    input  logic            i_BOOTEN_n,
    input  logic            i_BSEN_n,
    input  logic            i_4BEN_n,
    input  logic [NCH-1:0]  i_CH_MASK,
    input  logic [TO_W-1:0] i_TO_LIM,
    output logic            o_SYNCTIP_n,
    output logic            o_SYNCED_FLAG,
    output logic            o_SYNC_FAIL,
    output logic [NCH-1:0]  o_TIP_CH
);

    localparam logic [7:0] ZR = 8'(ZERO_RUN);
    localparam logic [3:0] AW = 4'(ALIGN_WIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_ALIGN,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t                  state_q, state_d;
    logic [NCH-1:0][7:0]     zc_q, zc_d;
    logic [NCH-1:0]          tip_ch_q, tip_ch_d;
    logic [NCH-1:0]          tip, hits;
    logic [3:0]              win_q, win_d, win_nxt;
    logic [TO_W-1:0]         to_q, to_d, to_nxt;
    logic [DLY_2B-1:0]       dly_q, dly_d;
    logic                    synctip_q, synctip_d;
    logic                    en, run, cov, timeout, p;

    assign en  = ~i_CLK2M_PCEN_n;
    assign run = ((state_q == S_HUNT) || (state_q == S_ALIGN)) && !i_BSEN_n;

    // Tip qualification looks at the run length before this step's bit is absorbed.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            zc_d[k] = zc_q[k];
            tip[k]  = 1'b0;
            if (!run) begin
                zc_d[k] = '0;
            end else if (i_GLCNT_RD) begin
                if (i_BDI[k]) begin
                    tip[k]  = (zc_q[k] == ZR) && !i_SLOT_n && i_CH_MASK[k];
                    zc_d[k] = '0;
                end else if (zc_q[k] != ZR) begin
                    zc_d[k] = zc_q[k] + 8'd1;
                end
            end
        end
    end

    assign hits    = tip_ch_q | tip;
    assign cov     = (i_CH_MASK != '0) && ((hits & i_CH_MASK) == i_CH_MASK);
    assign to_nxt  = to_q + TO_W'(1);
    assign win_nxt = win_q + 4'd1;
    assign timeout = (i_TO_LIM != '0) && (to_nxt == i_TO_LIM);

    always_comb begin
        state_d  = state_q;
        tip_ch_d = tip_ch_q;
        win_d    = win_q;
        to_d     = to_q;
        case (state_q)
            S_IDLE: begin
                if (!i_BOOTEN_n && !i_BSEN_n && (i_CH_MASK != '0)) begin
                    state_d  = S_HUNT;
                    tip_ch_d = '0;
                    to_d     = '0;
                    win_d    = '0;
                end
            end
            S_HUNT, S_ALIGN: begin
                if (i_BOOTEN_n) begin
                    state_d = S_IDLE;
                end else if (!i_BSEN_n && i_GLCNT_RD) begin
                    to_d = to_nxt;
                    // Timeout beats a lock decided on the same step.
                    if (timeout) begin
                        state_d = S_FAIL;
                    end else if (state_q == S_HUNT) begin
                        if (tip != '0) begin
                            tip_ch_d = hits;
                            if (cov) begin
                                state_d = S_LOCKED;
                            end else begin
                                state_d = S_ALIGN;
                                win_d   = '0;
                            end
                        end
                    end else begin
                        tip_ch_d = hits;
                        win_d    = win_nxt;
                        if (cov) begin
                            state_d = S_LOCKED;
                        end else if (win_nxt == AW) begin
                            state_d  = S_HUNT;
                            tip_ch_d = '0;
                        end
                    end
                end
            end
            S_LOCKED, S_FAIL: begin
                if (i_BOOTEN_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign p = (state_d == S_LOCKED) && (state_q != S_LOCKED);

    // 2-bit mode delays the pulse through the shift line; 4-bit mode flushes it.
    always_comb begin
        dly_d     = '0;
        synctip_d = ~p;
        if (i_4BEN_n) begin
            dly_d     = (dly_q << 1) | DLY_2B'(p);
            synctip_d = ~dly_q[DLY_2B-1];
        end
    end

    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            state_q   <= S_IDLE;
            zc_q      <= '0;
            tip_ch_q  <= '0;
            win_q     <= '0;
            to_q      <= '0;
            dly_q     <= '0;
            synctip_q <= 1'b1;
        end else if (en) begin
            state_q   <= state_d;
            zc_q      <= zc_d;
            tip_ch_q  <= tip_ch_d;
            win_q     <= win_d;
            to_q      <= to_d;
            dly_q     <= dly_d;
            synctip_q <= synctip_d;
        end
    end

    assign o_SYNCTIP_n   = synctip_q;
    assign o_SYNCED_FLAG = (state_q == S_LOCKED);
    assign o_SYNC_FAIL   = (state_q == S_FAIL);
    assign o_TIP_CH      = tip_ch_q;

endmodule

// File: tb/tb_mdl_spdet_nch.sv
// tb/tb_mdl_spdet_nch.sv - directed self-checking bench for mdl_spdet_nch
module tb_mdl_spdet_nch;

    localparam int NCH  = 2;
    localparam int TO_W = 12;

    logic            clk;
    logic            rst_n;
    logic            pcen_n;
    logic [NCH-1:0]  bdi;
    logic            glcnt_rd;
    logic            slot_n;
    logic            booten_n;
    logic            bsen_n;
    logic            ben4_n;
    logic [NCH-1:0]  ch_mask;
    logic [TO_W-1:0] to_lim;
    logic            synctip_n;
    logic            synced;
    logic            sync_fail;
    logic [NCH-1:0]  tip_ch;

    int n_cmp = 0;
    int n_err = 0;
    logic any_low;

    mdl_spdet_nch #(
        .NCH(NCH), .ZERO_RUN(4), .ALIGN_WIN(3), .DLY_2B(8), .TO_W(TO_W)
    ) dut (
        .i_MCLK        (clk),
        .i_SYS_RST_n   (rst_n),
        .i_CLK2M_PCEN_n(pcen_n),
        .i_BDI         (bdi),
        .i_GLCNT_RD    (glcnt_rd),
        .i_SLOT_n      (slot_n),
        .i_BOOTEN_n    (booten_n),
        .i_BSEN_n      (bsen_n),
        .i_4BEN_n      (ben4_n),
        .i_CH_MASK     (ch_mask),
        .i_TO_LIM      (to_lim),
        .o_SYNCTIP_n   (synctip_n),
        .o_SYNCED_FLAG (synced),
        .o_SYNC_FAIL   (sync_fail),
        .o_TIP_CH      (tip_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [NCH-1:0] b, input logic s_n);
        bdi    = b;
        slot_n = s_n;
        @(posedge clk);
        #1;
    endtask

    task automatic zeros(input int n);
        repeat (n) cyc(2'b00, 1'b1);
    endtask

    task automatic enter();
        booten_n = 1'b0;
        bsen_n   = 1'b0;
        cyc(2'b00, 1'b1);
    endtask

    task automatic leave();
        booten_n = 1'b1;
        cyc(2'b00, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        pcen_n   = 1'b0;
        bdi      = '0;
        glcnt_rd = 1'b1;
        slot_n   = 1'b1;
        booten_n = 1'b1;
        bsen_n   = 1'b1;
        ben4_n   = 1'b0;
        ch_mask  = 2'b11;
        to_lim   = 12'd20;
        any_low  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_synctip", 32'(synctip_n), 32'd1);
        chk("rst_synced", 32'(synced), 32'd0);
        chk("rst_fail", 32'(sync_fail), 32'd0);
        chk("rst_tipch", 32'(tip_ch), 32'd0);
        rst_n = 1'b1;
        cyc(2'b00, 1'b1);

        // Same-step lock, 4-bit mode, with a non-step cycle that must be ignored
        enter();
        chk("t1_hunt_synced", 32'(synced), 32'd0);
        zeros(3);
        glcnt_rd = 1'b0;
        cyc(2'b11, 1'b0);
        chk("t1_nostep_tipch", 32'(tip_ch), 32'd0);
        glcnt_rd = 1'b1;
        zeros(1);
        cyc(2'b11, 1'b0);
        chk("t1_lock_synced", 32'(synced), 32'd1);
        chk("t1_lock_tipch", 32'(tip_ch), 32'd3);
        chk("t1_lock_pulse", 32'(synctip_n), 32'd0);
        zeros(1);
        chk("t1_pulse_end", 32'(synctip_n), 32'd1);
        pcen_n = 1'b1;
        booten_n = 1'b1;
        cyc(2'b00, 1'b1);
        chk("t1_noen_hold", 32'(synced), 32'd1);
        pcen_n = 1'b0;
        leave();
        chk("t1_idle_synced", 32'(synced), 32'd0);

        // Skew of 2 steps
        enter();
        zeros(4);
        cyc(2'b01, 1'b0);
        chk("t2_align_tipch", 32'(tip_ch), 32'd1);
        chk("t2_align_synced", 32'(synced), 32'd0);
        cyc(2'b00, 1'b1);
        cyc(2'b10, 1'b0);
        chk("t2_lock_synced", 32'(synced), 32'd1);
        chk("t2_lock_tipch", 32'(tip_ch), 32'd3);
        leave();

        // Skew of 3 steps: lock ties with window expiry and wins
        enter();
        zeros(4);
        cyc(2'b01, 1'b0);
        zeros(2);
        chk("t2b_still_align", 32'(synced), 32'd0);
        cyc(2'b10, 1'b0);
        chk("t2b_tie_lock", 32'(synced), 32'd1);
        leave();

        // Window expiry without coverage returns to HUNT
        enter();
        zeros(4);
        cyc(2'b01, 1'b0);
        zeros(3);
        chk("t2c_expire_tipch", 32'(tip_ch), 32'd0);
        chk("t2c_expire_synced", 32'(synced), 32'd0);
        cyc(2'b10, 1'b0);
        chk("t2c_rehunt_tipch", 32'(tip_ch), 32'd2);
        leave();

        // Invalid patterns: short run, then slot closed
        enter();
        zeros(3);
        cyc(2'b11, 1'b0);
        chk("t3_short_run", 32'(tip_ch), 32'd0);
        zeros(4);
        cyc(2'b11, 1'b1);
        chk("t3_slot_closed", 32'(tip_ch), 32'd0);
        chk("t3_slot_synced", 32'(synced), 32'd0);
        zeros(4);
        cyc(2'b11, 1'b0);
        chk("t3_valid_lock", 32'(synced), 32'd1);
        chk("t3_valid_tipch", 32'(tip_ch), 32'd3);
        leave();

        // Timeout at step 20, taking priority over a same-step lock
        enter();
        zeros(19);
        chk("t4_pre_timeout", 32'(sync_fail), 32'd0);
        cyc(2'b11, 1'b0);
        chk("t4_fail", 32'(sync_fail), 32'd1);
        chk("t4_fail_nolock", 32'(synced), 32'd0);
        chk("t4_fail_nopulse", 32'(synctip_n), 32'd1);
        leave();
        chk("t4_idle_fail", 32'(sync_fail), 32'd0);
        chk("t4_idle_synced", 32'(synced), 32'd0);

        // Timeout disabled
        to_lim = 12'd0;
        enter();
        zeros(30);
        chk("t4b_nofail", 32'(sync_fail), 32'd0);
        cyc(2'b11, 1'b0);
        chk("t4b_lock", 32'(synced), 32'd1);
        leave();
        to_lim = 12'd20;

        // 2-bit mode: pulse 8 enable cycles after the flag, one disabled cycle inside
        ben4_n = 1'b1;
        enter();
        zeros(4);
        cyc(2'b11, 1'b0);
        chk("t5_lock", 32'(synced), 32'd1);
        chk("t5_no_early", 32'(synctip_n), 32'd1);
        any_low = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 4) begin
                pcen_n = 1'b1;
                cyc(2'b00, 1'b1);
                any_low = any_low | ~synctip_n;
                pcen_n = 1'b0;
            end
            cyc(2'b00, 1'b1);
            any_low = any_low | ~synctip_n;
        end
        chk("t5_quiet_delay", 32'(any_low), 32'd0);
        cyc(2'b00, 1'b1);
        chk("t5_pulse", 32'(synctip_n), 32'd0);
        cyc(2'b00, 1'b1);
        chk("t5_pulse_end", 32'(synctip_n), 32'd1);
        leave();

        // Mode change mid-delay drops the pulse
        enter();
        zeros(4);
        cyc(2'b11, 1'b0);
        chk("t5b_lock", 32'(synced), 32'd1);
        zeros(3);
        ben4_n = 1'b0;
        any_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(2'b00, 1'b1);
            any_low = any_low | ~synctip_n;
        end
        chk("t5b_dropped", 32'(any_low), 32'd0);
        leave();

        // Async reset in ALIGN
        enter();
        zeros(4);
        cyc(2'b01, 1'b0);
        chk("t6_align_tipch", 32'(tip_ch), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("t6a_tipch", 32'(tip_ch), 32'd0);
        chk("t6a_synced", 32'(synced), 32'd0);
        chk("t6a_synctip", 32'(synctip_n), 32'd1);
        booten_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2'b00, 1'b1);

        // Async reset in LOCKED during the 4-bit pulse
        enter();
        zeros(4);
        cyc(2'b11, 1'b0);
        chk("t6b_pulse", 32'(synctip_n), 32'd0);
        rst_n = 1'b0;
        #2;
        chk("t6b_synctip", 32'(synctip_n), 32'd1);
        chk("t6b_synced", 32'(synced), 32'd0);
        chk("t6b_tipch", 32'(tip_ch), 32'd0);
        booten_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        any_low = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 1'b1);
            any_low = any_low | ~synctip_n;
        end
        chk("t6b_no_post_pulse", 32'(any_low), 32'd0);

        // Pause in HUNT: timers hold, zero runs restart
        enter();
        zeros(2);
        bsen_n = 1'b1;
        zeros(5);
        bsen_n = 1'b0;
        zeros(3);
        cyc(2'b11, 1'b0);
        chk("t6c_run_restarted", 32'(tip_ch), 32'd0);
        chk("t6c_no_lock", 32'(synced), 32'd0);
        zeros(13);
        chk("t6c_timer_held", 32'(sync_fail), 32'd0);
        zeros(1);
        chk("t6c_fail", 32'(sync_fail), 32'd1);
        leave();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
